// File: rtl/lcd_draw_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module : lcd_draw_scheduler_if
// Desc   : Job handshake bundle for the two cell-draw requesters.
// Rev    : 1.0
// ============================================================================
interface lcd_draw_scheduler_if;
  logic       req0_valid;
  logic [5:0] req0_pos;
  logic [1:0] req0_img;
  logic       req0_ready;
  logic       req1_valid;
  logic [5:0] req1_pos;
  logic [1:0] req1_img;
  logic       req1_ready;

  modport master (
    output req0_valid, req0_pos, req0_img,
    output req1_valid, req1_pos, req1_img,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_pos, req0_img,
    input  req1_valid, req1_pos, req1_img,
    output req0_ready, req1_ready
  );
endinterface
`default_nettype wire

// File: rtl/lcd_draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module : lcd_draw_scheduler
// Desc   : Round-robin job arbiter, job FIFO and LCD init/clear/draw sequencer.
// Rev    : 1.0
// ============================================================================
module lcd_draw_scheduler #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 LCD_CLK,
  input  logic                 RESETN,
  lcd_draw_scheduler_if.slave  req,
  output logic [7:0]           LCD_DATA,
  output logic                 LCD_DI,
  output logic                 LCD_RW,
  output logic                 LCD_ENABLE,
  output logic                 LCD_CS1,
  output logic                 LCD_CS2,
  output logic                 LCD_RSTN,
  output logic                 init_done,
  output logic                 busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] c_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_STARTLINE = 4'd1,
    S_CLR_PAGE  = 4'd2,
    S_CLR_COL   = 4'd3,
    S_CLR_DATA  = 4'd4,
    S_IDLE      = 4'd5,
    S_PAGE      = 4'd6,
    S_COL       = 4'd7,
    S_DATA      = 4'd8
  } state_t;

  state_t         state_q;
  logic [7:0]     data_q;
  logic           di_q;
  logic           en_q;
  logic           init_done_q;
  logic [2:0]     clr_page_q;
  logic [5:0]     clr_col_q;
  logic [2:0]     byte_idx_q;
  logic [5:0]     job_pos_q;
  logic [1:0]     job_img_q;

  logic [7:0]     fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q;
  logic [PW-1:0]  rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           last_q;

  logic           can_push_w;
  logic           grant0_w;
  logic           grant1_w;
  logic           push_w;
  logic           pop_w;
  logic [7:0]     push_data_w;

  // Byte 0 of each image sits in the most significant byte of its row.
  function automatic logic [7:0] pattern_byte(input logic [1:0] img, input logic [2:0] idx);
    logic [63:0] row;
    case (img)
      2'd0:    row = 64'h0000000000000000;
      2'd1:    row = 64'h00187EFFFF7E1800;
      2'd2:    row = 64'h00187EC3C37E1800;
      default: row = 64'h0000183C3C180000;
    endcase
    return row[{~idx, 3'b000} +: 8];
  endfunction

  // Ready uses the registered count only, so a full FIFO refuses a push even on a pop cycle.
  assign can_push_w  = init_done_q && (count_q != c_FULL);
  assign grant0_w    = can_push_w && req.req0_valid && (!req.req1_valid || last_q);
  assign grant1_w    = can_push_w && req.req1_valid && (!req.req0_valid || !last_q);
  assign push_w      = grant0_w || grant1_w;
  assign pop_w       = (state_q == S_IDLE) && (count_q != '0);
  assign push_data_w = grant1_w ? {req.req1_img, req.req1_pos}
                                : {req.req0_img, req.req0_pos};

  assign req.req0_ready = grant0_w;
  assign req.req1_ready = grant1_w;

  always_ff @(posedge LCD_CLK or negedge RESETN) begin
    if (!RESETN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= 1'b1;
    end else begin
      if (push_w) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
        last_q   <= grant1_w;
      end
      if (pop_w) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push_w && !pop_w) begin
        count_q <= count_q + CW'(1);
      end else if (!push_w && pop_w) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge LCD_CLK) begin
    if (push_w) begin
      fifo_mem_q[wr_ptr_q] <= push_data_w;
    end
  end

  always_ff @(posedge LCD_CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= S_INIT;
      data_q      <= 8'h00;
      di_q        <= 1'b0;
      en_q        <= 1'b0;
      init_done_q <= 1'b0;
      clr_page_q  <= '0;
      clr_col_q   <= '0;
      byte_idx_q  <= '0;
      job_pos_q   <= '0;
      job_img_q   <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          data_q  <= 8'h3F;
          di_q    <= 1'b0;
          en_q    <= 1'b1;
          state_q <= S_STARTLINE;
        end
        S_STARTLINE: begin
          data_q     <= 8'hC0;
          di_q       <= 1'b0;
          en_q       <= 1'b1;
          clr_page_q <= '0;
          state_q    <= S_CLR_PAGE;
        end
        S_CLR_PAGE: begin
          data_q  <= {5'b10111, clr_page_q};
          di_q    <= 1'b0;
          en_q    <= 1'b1;
          state_q <= S_CLR_COL;
        end
        S_CLR_COL: begin
          data_q    <= 8'h40;
          di_q      <= 1'b0;
          en_q      <= 1'b1;
          clr_col_q <= '0;
          state_q   <= S_CLR_DATA;
        end
        S_CLR_DATA: begin
          data_q    <= 8'h00;
          di_q      <= 1'b1;
          en_q      <= 1'b1;
          clr_col_q <= clr_col_q + 6'd1;
          if (clr_col_q == 6'd63) begin
            if (clr_page_q == 3'd7) begin
              state_q <= S_IDLE;
            end else begin
              clr_page_q <= clr_page_q + 3'd1;
              state_q    <= S_CLR_PAGE;
            end
          end
        end
        S_IDLE: begin
          en_q        <= 1'b0;
          init_done_q <= 1'b1;
          if (pop_w) begin
            {job_img_q, job_pos_q} <= fifo_mem_q[rd_ptr_q];
            state_q                <= S_PAGE;
          end
        end
        S_PAGE: begin
          data_q  <= {5'b10111, job_pos_q[5:3]};
          di_q    <= 1'b0;
          en_q    <= 1'b1;
          state_q <= S_COL;
        end
        S_COL: begin
          data_q     <= {2'b01, job_pos_q[2:0], 3'b000};
          di_q       <= 1'b0;
          en_q       <= 1'b1;
          byte_idx_q <= '0;
          state_q    <= S_DATA;
        end
        S_DATA: begin
          data_q     <= pattern_byte(job_img_q, byte_idx_q);
          di_q       <= 1'b1;
          en_q       <= 1'b1;
          byte_idx_q <= byte_idx_q + 3'd1;
          if (byte_idx_q == 3'd7) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

  assign LCD_DATA   = data_q;
  assign LCD_DI     = di_q;
  assign LCD_RW     = 1'b0;
  // The LCD latches on the falling edge, so enable is a gated copy of the clock.
  assign LCD_ENABLE = LCD_CLK & en_q;
  assign LCD_CS1    = 1'b1;
  assign LCD_CS2    = 1'b0;
  assign LCD_RSTN   = RESETN;
  assign init_done  = init_done_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_lcd_draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_lcd_draw_scheduler
// Desc   : Scoreboard bench with a transaction-level model of the LCD scheduler.
// Rev    : 1.0
// ============================================================================
module tb_lcd_draw_scheduler;

  localparam int DEPTH       = 4;
  localparam int INIT_WRITES = 2 + 8 * 66;
  localparam int JOB_CYCLES  = 11;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  lcd_draw_scheduler_if bus ();

  logic [7:0] lcd_data;
  logic       lcd_di, lcd_rw, lcd_en, lcd_cs1, lcd_cs2, lcd_rstn, init_done, busy;

  lcd_draw_scheduler #(.FIFO_DEPTH(DEPTH)) dut (
    .LCD_CLK    (clk),
    .RESETN     (rstn),
    .req        (bus),
    .LCD_DATA   (lcd_data),
    .LCD_DI     (lcd_di),
    .LCD_RW     (lcd_rw),
    .LCD_ENABLE (lcd_en),
    .LCD_CS1    (lcd_cs1),
    .LCD_CS2    (lcd_cs2),
    .LCD_RSTN   (lcd_rstn),
    .init_done  (init_done),
    .busy       (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Expected bus writes {DI, DATA} in order, and the model's job queue {img, pos}.
  logic [8:0] exp_q [$];
  logic [7:0] job_q [$];

  int  edge_n    = 0;
  int  next_idle = INIT_WRITES + 1;
  int  last_pop  = 0;
  bit  m_last    = 1'b1;
  bit  m_in_rst  = 1'b0;
  bit  m_room, m_g0, m_g1;
  bit  mon_en, mon_idle;
  logic [8:0] mon_w;

  logic [7:0] pats [0:3][0:7] = '{
    '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h00, 8'h18, 8'h7E, 8'hFF, 8'hFF, 8'h7E, 8'h18, 8'h00},
    '{8'h00, 8'h18, 8'h7E, 8'hC3, 8'hC3, 8'h7E, 8'h18, 8'h00},
    '{8'h00, 8'h00, 8'h18, 8'h3C, 8'h3C, 8'h18, 8'h00, 8'h00}
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_init_writes();
    exp_q.push_back({1'b0, 8'h3F});
    exp_q.push_back({1'b0, 8'hC0});
    for (int p = 0; p < 8; p++) begin
      exp_q.push_back({1'b0, 8'hB8 + 8'(p)});
      exp_q.push_back({1'b0, 8'h40});
      for (int c = 0; c < 64; c++) exp_q.push_back({1'b1, 8'h00});
    end
  endtask

  task automatic push_job_writes(input logic [5:0] pos, input logic [1:0] img);
    exp_q.push_back({1'b0, 8'hB8 + 8'(pos / 8)});
    exp_q.push_back({1'b0, 8'h40 + 8'((pos % 8) * 8)});
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, pats[img][i]});
  endtask

  // Reference model: predicts the effect of the coming rising edge from stable inputs.
  always @(negedge clk) begin
    if (!rstn) begin
      if (!m_in_rst) begin
        exp_q.delete();
        job_q.delete();
        push_init_writes();
      end
      m_in_rst  = 1'b1;
      edge_n    = 0;
      next_idle = INIT_WRITES + 1;
      last_pop  = 0;
      m_last    = 1'b1;
    end else begin
      m_in_rst = 1'b0;
      edge_n++;
      m_room = (edge_n >= INIT_WRITES + 2) && (job_q.size() < DEPTH);
      m_g0   = m_room && bus.req0_valid && (!bus.req1_valid || m_last);
      m_g1   = m_room && bus.req1_valid && (!bus.req0_valid || !m_last);
      check("req0_ready", bus.req0_ready, m_g0);
      check("req1_ready", bus.req1_ready, m_g1);
      if (edge_n >= next_idle && job_q.size() > 0) begin
        void'(job_q.pop_front());
        last_pop  = edge_n;
        next_idle = edge_n + JOB_CYCLES;
      end
      if (m_g0) begin
        job_q.push_back({bus.req0_img, bus.req0_pos});
        push_job_writes(bus.req0_pos, bus.req0_img);
        m_last = 1'b0;
      end else if (m_g1) begin
        job_q.push_back({bus.req1_img, bus.req1_pos});
        push_job_writes(bus.req1_pos, bus.req1_img);
        m_last = 1'b1;
      end
    end
  end

  // Monitor: checks the bus just after each rising edge while enable mirrors en_q.
  always @(posedge clk) begin
    #1;
    if (!rstn) begin
      check("rst_data", lcd_data, 8'h00);
      check("rst_di", lcd_di, 1'b0);
      check("rst_enable", lcd_en, 1'b0);
      check("rst_init_done", init_done, 1'b0);
      check("rst_busy", busy, 1'b1);
      check("rst_ready0", bus.req0_ready, 1'b0);
      check("rst_ready1", bus.req1_ready, 1'b0);
      check("rst_lcd_rstn", lcd_rstn, 1'b0);
    end else begin
      mon_en = ((edge_n >= 1) && (edge_n <= INIT_WRITES)) ||
               ((last_pop > 0) && (edge_n > last_pop) && (edge_n <= last_pop + 10));
      check("enable", lcd_en, mon_en);
      if (lcd_en) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL write_extra: got %0h, expected no write (t=%0t)", {lcd_di, lcd_data}, $time);
        end else begin
          mon_w = exp_q.pop_front();
          check("write", {lcd_di, lcd_data}, mon_w);
        end
      end
      check("init_done", init_done, edge_n >= INIT_WRITES + 1);
      mon_idle = (edge_n >= INIT_WRITES) &&
                 !((last_pop > 0) && (edge_n >= last_pop) && (edge_n <= last_pop + 9));
      check("busy", busy, !mon_idle || (job_q.size() != 0));
      check("rw", lcd_rw, 1'b0);
      check("cs", {lcd_cs1, lcd_cs2, lcd_rstn}, 3'b101);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Holds one port valid until it is granted, bounded.
  task automatic send(input int port, input logic [5:0] pos, input logic [1:0] img);
    bit got;
    got = 1'b0;
    if (port == 0) begin
      bus.req0_pos = pos; bus.req0_img = img; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_pos = pos; bus.req1_img = img; bus.req1_valid = 1'b1;
    end
    for (int k = 0; k < 3000 && !got; k++) begin
      @(negedge clk);
      got = (port == 0) ? bus.req0_ready : bus.req1_ready;
    end
    @(posedge clk);
    #2;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got no grant, expected grant on port %0d", port);
    end
  endtask

  initial begin
    int cnt;
    bus.req0_valid = 1'b0; bus.req0_pos = '0; bus.req0_img = '0;
    bus.req1_valid = 1'b0; bus.req1_pos = '0; bus.req1_img = '0;
    rstn = 1'b0;
    step(3);
    rstn = 1'b1;
    step(INIT_WRITES + 10);

    send(0, 6'o35, 2'd1);
    step(20);

    bus.req0_pos = 6'o12; bus.req0_img = 2'd1;
    bus.req1_pos = 6'o47; bus.req1_img = 2'd2;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    step(60);
    bus.req1_valid = 1'b0;
    step(30);
    bus.req0_valid = 1'b0;
    step(70);

    send(0, 6'o01, 2'd1);
    send(0, 6'o22, 2'd2);
    send(0, 6'o63, 2'd3);
    cnt = 0;
    for (int k = 0; k < 200 && cnt < 5; k++) begin
      @(posedge clk);
      #1;
      if (lcd_en && lcd_di) cnt++;
    end
    #1;
    if (cnt < 5) begin
      n_cmp++;
      n_err++;
      $display("FAIL data_wait: got %0d data bytes, expected 5", cnt);
    end
    rstn = 1'b0;
    step(4);
    rstn = 1'b1;
    step(INIT_WRITES + 10);

    send(1, 6'o00, 2'd3);
    send(1, 6'o00, 2'd0);
    step(30);

    repeat (400) begin
      bus.req0_valid = ($urandom_range(0, 2) != 0);
      bus.req1_valid = ($urandom_range(0, 2) != 0);
      bus.req0_pos   = 6'($urandom);
      bus.req1_pos   = 6'($urandom);
      bus.req0_img   = 2'($urandom);
      bus.req1_img   = 2'($urandom);
      step(1);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    step(80);

    check("drained", exp_q.size(), 0);
    check("idle_busy", busy, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
